mod_exp_ctrl: RTL and testbench

Modular-exponentiation controller: computes base^exp mod m by right-to-left square-and-multiply. It sits directly upstream of the serial modulus-reduction block. It forms each 2·WIDTH-bit product and hands it to the reducer (instantiated at top level with its width parameter = 2·WIDTH). It then consumes the reduced result and sequences the next operation. It is the key-arithmetic engine for the keychain's public/private-key operations.

---
 rtl/mod_exp_ctrl_if.sv | 34 +++
 rtl/mod_exp_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_mod_exp_ctrl.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mod_exp_ctrl_if.sv
// Signal bundle between the modular-exponentiation controller, its requester
// and the downstream serial modulus reducer.
interface mod_exp_ctrl_if #(parameter int WIDTH = 16);
  logic                 start_in;
  logic [WIDTH-1:0]     base_in;
  logic [WIDTH-1:0]     exp_in;
  logic [WIDTH-1:0]     modulus_in;
  logic [WIDTH-1:0]     result_out;
  logic                 busy_out;
  logic                 valid_out;
  logic                 err_out;
  logic                 red_start_out;
  logic [2*WIDTH-1:0]   red_value_out;
  logic [2*WIDTH-1:0]   red_modulus_out;
  logic                 red_busy_in;
  logic                 red_valid_in;
  logic [2*WIDTH-1:0]   red_value_in;

  // slave: the controller itself
  modport slave (
    input  start_in, base_in, exp_in, modulus_in,
    input  red_busy_in, red_valid_in, red_value_in,
    output result_out, busy_out, valid_out, err_out,
    output red_start_out, red_value_out, red_modulus_out
  );

  // master: requester plus reducer environment
  modport master (
    output start_in, base_in, exp_in, modulus_in,
    output red_busy_in, red_valid_in, red_value_in,
    input  result_out, busy_out, valid_out, err_out,
    input  red_start_out, red_value_out, red_modulus_out
  );
endinterface

// File: rtl/mod_exp_ctrl.sv
// Right-to-left square-and-multiply controller for base^exp mod m; every
// 2*WIDTH-bit product is handed to an external serial reducer.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start_in
// RBASE   | base reduction pending, issued once reducer is free
// RBASE_W | waiting for reduced base
// STEP    | choose next op (multiply, square or finish) for current e
// MUL_W   | acc*b pending/outstanding
// SQR_W   | b*b pending/outstanding
// DONE    | result presented (valid_out high); new start accepted here
module mod_exp_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic          clk_in,
  input  logic          rst_n_in,
  mod_exp_ctrl_if.slave bus
);
  localparam int W2 = 2 * WIDTH;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RBASE   = 3'd1;
  localparam logic [2:0] S_RBASE_W = 3'd2;
  localparam logic [2:0] S_STEP    = 3'd3;
  localparam logic [2:0] S_MUL_W   = 3'd4;
  localparam logic [2:0] S_SQR_W   = 3'd5;
  localparam logic [2:0] S_DONE    = 3'd6;

  logic [2:0]       state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] e_q, e_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [W2-1:0]    red_value_q, red_value_d;
  logic             pend_q, pend_d;
  logic             mul_done_q, mul_done_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;

  logic             issue;
  logic             red_ok;
  logic [WIDTH-1:0] red_lo;
  logic [WIDTH-1:0] e_shr;
  logic [W2-1:0]    acc_x, b_x;
  logic             unused_hi;

  // A request goes out only while the reducer is idle; otherwise it stays pending.
  assign issue     = pend_q & ~bus.red_busy_in;
  assign red_ok    = ~pend_q & bus.red_valid_in;
  assign red_lo    = bus.red_value_in[WIDTH-1:0];
  assign unused_hi = ^bus.red_value_in[W2-1:WIDTH];
  assign e_shr     = e_q >> 1;
  assign acc_x     = {{WIDTH{1'b0}}, acc_q};
  assign b_x       = {{WIDTH{1'b0}}, b_q};

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    b_d         = b_q;
    e_d         = e_q;
    m_d         = m_q;
    result_d    = result_q;
    red_value_d = red_value_q;
    pend_d      = pend_q;
    mul_done_d  = mul_done_q;
    busy_d      = busy_q;
    err_d       = err_q;
    valid_d     = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        if (bus.start_in) begin
          b_d        = bus.base_in;
          e_d        = bus.exp_in;
          m_d        = bus.modulus_in;
          acc_d      = {{(WIDTH-1){1'b0}}, 1'b1};
          mul_done_d = 1'b0;
          busy_d     = 1'b1;
          // Degenerate moduli and zero exponent resolve without the reducer.
          if (bus.modulus_in == '0) begin
            result_d = '0;
            err_d    = 1'b1;
            valid_d  = 1'b1;
            state_d  = S_DONE;
          end else if (bus.modulus_in == {{(WIDTH-1){1'b0}}, 1'b1}) begin
            result_d = '0;
            err_d    = 1'b0;
            valid_d  = 1'b1;
            state_d  = S_DONE;
          end else if (bus.exp_in == '0) begin
            result_d = {{(WIDTH-1){1'b0}}, 1'b1};
            err_d    = 1'b0;
            valid_d  = 1'b1;
            state_d  = S_DONE;
          end else begin
            red_value_d = {{WIDTH{1'b0}}, bus.base_in};
            pend_d      = 1'b1;
            state_d     = S_RBASE;
          end
        end
      end

      S_RBASE: begin
        if (issue) begin
          pend_d  = 1'b0;
          state_d = S_RBASE_W;
        end
      end

      S_RBASE_W: begin
        if (issue) begin
          pend_d = 1'b0;
        end else if (red_ok) begin
          b_d     = red_lo;
          state_d = S_STEP;
        end
      end

      S_STEP: begin
        if (e_q[0] && !mul_done_q) begin
          red_value_d = acc_x * b_x;
          pend_d      = 1'b1;
          state_d     = S_MUL_W;
        end else if (e_shr != '0) begin
          red_value_d = b_x * b_x;
          pend_d      = 1'b1;
          state_d     = S_SQR_W;
        end else begin
          e_d      = e_shr;
          result_d = acc_q;
          err_d    = 1'b0;
          valid_d  = 1'b1;
          busy_d   = 1'b0;
          state_d  = S_DONE;
        end
      end

      S_MUL_W: begin
        if (issue) begin
          pend_d = 1'b0;
        end else if (red_ok) begin
          acc_d = red_lo;
          // Final multiply: publish directly so the result lands one cycle after the reducer.
          if (e_shr == '0) begin
            e_d      = '0;
            result_d = red_lo;
            err_d    = 1'b0;
            valid_d  = 1'b1;
            busy_d   = 1'b0;
            state_d  = S_DONE;
          end else begin
            mul_done_d = 1'b1;
            state_d    = S_STEP;
          end
        end
      end

      S_SQR_W: begin
        if (issue) begin
          pend_d = 1'b0;
        end else if (red_ok) begin
          b_d        = red_lo;
          e_d        = e_shr;
          mul_done_d = 1'b0;
          state_d    = S_STEP;
        end
      end

      default: begin
        state_d = S_IDLE;
        pend_d  = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      b_q         <= '0;
      e_q         <= '0;
      m_q         <= '0;
      result_q    <= '0;
      red_value_q <= '0;
      pend_q      <= 1'b0;
      mul_done_q  <= 1'b0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      b_q         <= b_d;
      e_q         <= e_d;
      m_q         <= m_d;
      result_q    <= result_d;
      red_value_q <= red_value_d;
      pend_q      <= pend_d;
      mul_done_q  <= mul_done_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

  assign bus.result_out      = result_q;
  assign bus.busy_out        = busy_q;
  assign bus.valid_out       = valid_q;
  assign bus.err_out         = err_q;
  assign bus.red_start_out   = issue;
  assign bus.red_value_out   = red_value_q;
  assign bus.red_modulus_out = {{WIDTH{1'b0}}, m_q};
endmodule

// File: tb/tb_mod_exp_ctrl.sv
// Directed and randomized bench for mod_exp_ctrl with a behavioural reducer
// (configurable latency, idle busy noise, optional stray result pulses).
module tb_mod_exp_ctrl;
  localparam int WIDTH = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mod_exp_ctrl_if #(.WIDTH(WIDTH)) bus ();

  mod_exp_ctrl #(.WIDTH(WIDTH)) dut (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .bus      (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  // reducer model state
  bit          noise_en     = 1'b0;
  bit          spur_en      = 1'b0;
  bit          spur_pending = 1'b0;
  bit          outstanding  = 1'b0;
  bit          prev_start   = 1'b0;
  int          lat_min      = 1;
  int          lat_max      = 1;
  int          cnt          = 0;
  int          issued       = 0;
  int          viol         = 0;
  logic [31:0] req_val      = '0;
  logic [31:0] req_mod      = '0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic logic [15:0] ref_modexp(input logic [15:0] b, input logic [15:0] e,
                                              input logic [15:0] m);
    logic [31:0] r, x, mm;
    logic [15:0] k;
    if (m == 16'd0 || m == 16'd1) return 16'd0;
    mm = {16'd0, m};
    r  = 32'd1;
    x  = {16'd0, b} % mm;
    k  = e;
    while (k != 16'd0) begin
      if (k[0]) r = (r * x) % mm;
      x = (x * x) % mm;
      k = k >> 1;
    end
    return r[15:0];
  endfunction

  function automatic int nred(input logic [15:0] e);
    int msb;
    msb = 0;
    if (e == 16'd0) return 0;
    for (int i = 0; i < 16; i++) if (e[i]) msb = i;
    return 1 + $countones(e) + msb;
  endfunction

  // Reducer: watches requests on the falling edge, updates its outputs just after the rising edge.
  initial begin
    bus.red_busy_in  = 1'b0;
    bus.red_valid_in = 1'b0;
    bus.red_value_in = '0;
    forever begin
      @(negedge clk);
      if (bus.red_start_out) begin
        if (bus.red_busy_in || outstanding || prev_start) viol++;
        req_val     = bus.red_value_out;
        req_mod     = bus.red_modulus_out;
        outstanding = 1'b1;
        cnt         = $urandom_range(lat_max, lat_min);
        issued++;
      end
      prev_start = bus.red_start_out;
      @(posedge clk);
      #1;
      bus.red_valid_in = 1'b0;
      if (spur_pending) begin
        bus.red_valid_in = 1'b1;
        bus.red_value_in = 32'h0000_BEEF;
        spur_pending     = 1'b0;
      end else if (outstanding) begin
        cnt--;
        if (cnt == 0) begin
          bus.red_valid_in = 1'b1;
          bus.red_value_in = req_val % req_mod;
          bus.red_busy_in  = 1'b0;
          outstanding      = 1'b0;
          if (spur_en) spur_pending = 1'b1;
        end else begin
          bus.red_busy_in = 1'b1;
        end
      end else begin
        bus.red_busy_in = noise_en && ($urandom_range(3, 0) == 0);
      end
    end
  end

  // exp_cyc: cycles from accept to valid_out (-1 = don't check); poke: spam start_in while busy;
  // now: drive start_in in the current cycle instead of waiting for the next one.
  task automatic run_op(input string tag, input logic [15:0] b, input logic [15:0] e,
                        input logic [15:0] m, input logic [15:0] exp_res, input logic exp_err,
                        input int exp_red, input int exp_cyc, input bit poke, input bit now);
    int cyc;
    int iss0;
    if (!now) begin
      @(posedge clk);
      #2;
    end
    bus.start_in   = 1'b1;
    bus.base_in    = b;
    bus.exp_in     = e;
    bus.modulus_in = m;
    iss0 = issued;
    @(posedge clk);
    #2;
    bus.start_in = 1'b0;
    chk({tag, "_busy_t1"}, {31'd0, bus.busy_out}, 32'd1);
    if (exp_cyc > 1) begin
      chk({tag, "_first_start"}, {31'd0, bus.red_start_out}, 32'd1);
      chk({tag, "_first_value"}, bus.red_value_out, {16'd0, b});
    end
    cyc = 1;
    while (!bus.valid_out && cyc < 6000) begin
      if (poke) begin
        bus.start_in   = cyc[0];
        bus.base_in    = 16'h5555;
        bus.exp_in     = 16'h00FF;
        bus.modulus_in = 16'd3;
      end
      @(posedge clk);
      #2;
      cyc++;
    end
    bus.start_in = 1'b0;
    chk({tag, "_valid"}, {31'd0, bus.valid_out}, 32'd1);
    if (exp_cyc > 0) chk({tag, "_latency"}, cyc, exp_cyc);
    chk({tag, "_result"}, {16'd0, bus.result_out}, {16'd0, exp_res});
    chk({tag, "_err"}, {31'd0, bus.err_out}, {31'd0, exp_err});
    chk({tag, "_busy_at_valid"}, {31'd0, bus.busy_out}, (exp_red == 0) ? 32'd1 : 32'd0);
    chk({tag, "_reductions"}, issued - iss0, exp_red);
  endtask

  initial begin
    int iss0;
    int cyc;
    bit saw_valid;
    logic [15:0] rb, re, rm;

    bus.start_in   = 1'b0;
    bus.base_in    = '0;
    bus.exp_in     = '0;
    bus.modulus_in = '0;

    repeat (3) @(posedge clk);
    #2;
    chk("rst_result", {16'd0, bus.result_out}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy_out}, 32'd0);
    chk("rst_valid", {31'd0, bus.valid_out}, 32'd0);
    chk("rst_err", {31'd0, bus.err_out}, 32'd0);
    chk("rst_red_start", {31'd0, bus.red_start_out}, 32'd0);
    chk("rst_red_value", bus.red_value_out, 32'd0);
    chk("rst_red_mod", bus.red_modulus_out, 32'd0);
    rst_n = 1'b1;

    // directed, fixed latency, reducer otherwise idle
    run_op("p4_13_497", 16'd4, 16'd13, 16'd497, 16'd445, 1'b0, 7, 7 * 3, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    chk("pulse_once", {31'd0, bus.valid_out}, 32'd0);
    chk("result_held", {16'd0, bus.result_out}, 32'd445);

    lat_min = 4;
    lat_max = 4;
    run_op("p2_10_1000", 16'd2, 16'd10, 16'd1000, 16'd24, 1'b0, 6, 6 * 6, 1'b0, 1'b0);
    run_op("rbase", 16'd1234, 16'd1, 16'd1000, 16'd234, 1'b0, 2, 2 * 6, 1'b0, 1'b0);
    run_op("exp0", 16'd9, 16'd0, 16'd7, 16'd1, 1'b0, 0, 1, 1'b0, 1'b0);
    run_op("mod1", 16'd77, 16'd5, 16'd1, 16'd0, 1'b0, 0, 1, 1'b0, 1'b0);
    run_op("mod0", 16'd77, 16'd5, 16'd0, 16'd0, 1'b1, 0, 1, 1'b0, 1'b0);
    // start_in during the valid_out cycle of the previous op
    run_op("restart", 16'd3, 16'd5, 16'd13, 16'd9, 1'b0, 5, 5 * 6, 1'b0, 1'b1);

    // start spam and stray reducer results after every genuine one
    lat_min = 3;
    lat_max = 3;
    spur_en = 1'b1;
    run_op("poke_spur", 16'd4, 16'd13, 16'd497, 16'd445, 1'b0, 7, 7 * 5, 1'b1, 1'b0);
    spur_en = 1'b0;
    repeat (2) @(posedge clk);

    // asynchronous reset while a multiply is outstanding
    lat_min = 10;
    lat_max = 10;
    @(posedge clk);
    #2;
    bus.start_in   = 1'b1;
    bus.base_in    = 16'd4;
    bus.exp_in     = 16'd13;
    bus.modulus_in = 16'd497;
    iss0 = issued;
    @(posedge clk);
    #2;
    bus.start_in = 1'b0;
    cyc = 0;
    while ((issued - iss0) < 2 && cyc < 200) begin
      @(posedge clk);
      #2;
      cyc++;
    end
    chk("mulw_reached", issued - iss0, 2);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", {31'd0, bus.busy_out}, 32'd0);
    chk("arst_result", {16'd0, bus.result_out}, 32'd0);
    chk("arst_red_value", bus.red_value_out, 32'd0);
    chk("arst_red_mod", bus.red_modulus_out, 32'd0);
    chk("arst_red_start", {31'd0, bus.red_start_out}, 32'd0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    saw_valid = 1'b0;
    cyc = 0;
    while ((outstanding || cyc < 3) && cyc < 100) begin
      @(posedge clk);
      #2;
      saw_valid = saw_valid | bus.valid_out | bus.busy_out;
      cyc++;
    end
    chk("stale_ignored", {31'd0, saw_valid}, 32'd0);
    run_op("after_rst", 16'd3, 16'd5, 16'd13, 16'd9, 1'b0, 5, 5 * 12, 1'b0, 1'b0);

    // random operands against the reference, random latency and busy noise
    noise_en = 1'b1;
    lat_min  = 1;
    lat_max  = 40;
    for (int i = 0; i < 50; i++) begin
      rb = 16'($urandom);
      re = 16'($urandom);
      rm = 16'($urandom_range(65535, 2));
      run_op($sformatf("rnd%0d", i), rb, re, rm, ref_modexp(rb, re, rm), 1'b0, nred(re), -1,
             1'b0, 1'b0);
    end
    chk("issue_protocol", viol, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
